// File: rtl/ram_block_mover_pkg.sv
// Shared encodings and default geometry for the block mover and the 32x8 RAM it drives.
package ram_block_mover_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_block_mover_if.sv
// Command/response channel between the CPU datapath (master) and the block mover (slave).
interface ram_block_mover_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, done
  );
endinterface

// File: rtl/ram_block_mover.sv
// Sole initiator on the synchronous RAM port: runs READ/WRITE/FILL/COPY commands as
// sequences of single-word accesses, all outputs registered.
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_block_mover_if.slave  cmd,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              done_q, done_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  op_e               cmd_op_in;
  assign cmd_op_in = op_e'(cmd.cmd_op);

  // Output registers are loaded with the values belonging to the state being entered,
  // so cnt_q counts the words still to go after the access currently on the bus.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd.cmd_valid) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op_in;
          dst_d       = cmd.cmd_dst;
          src_d       = cmd.cmd_src;
          data_d      = cmd.cmd_data;
          cnt_d       = cmd.cmd_len - LEN_W'(1);
          unique case (cmd_op_in)
            OP_READ: begin
              state_d    = ST_RD;
              ram_cs_d   = 1'b1;
              ram_addr_d = cmd.cmd_dst;
            end
            OP_WRITE: begin
              state_d     = ST_WR;
              ram_cs_d    = 1'b1;
              ram_we_d    = 1'b1;
              ram_addr_d  = cmd.cmd_dst;
              ram_wdata_d = cmd.cmd_data;
            end
            OP_FILL: begin
              if (cmd.cmd_len == '0) begin
                state_d = ST_FIN;
                done_d  = 1'b1;
              end else begin
                state_d     = ST_WR;
                ram_cs_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = cmd.cmd_dst;
                ram_wdata_d = cmd.cmd_data;
                dst_d       = cmd.cmd_dst + ADDR_W'(1);
              end
            end
            OP_COPY: begin
              if (cmd.cmd_len == '0) begin
                state_d = ST_FIN;
                done_d  = 1'b1;
              end else begin
                state_d    = ST_RD;
                ram_cs_d   = 1'b1;
                ram_addr_d = cmd.cmd_src;
                src_d      = cmd.cmd_src + ADDR_W'(1);
              end
            end
            default: ;
          endcase
        end
      end

      ST_RD: begin
        state_d = ST_CAP;
      end

      // RAM output is valid this cycle; it lands straight in the response or write-data register.
      ST_CAP: begin
        if (op_q == OP_READ) begin
          state_d     = ST_FIN;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ram_rdata;
          done_d      = 1'b1;
        end else begin
          state_d     = ST_WR;
          ram_cs_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = dst_q;
          ram_wdata_d = ram_rdata;
          dst_d       = dst_q + ADDR_W'(1);
        end
      end

      ST_WR: begin
        if (op_q == OP_WRITE || cnt_q == '0) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (op_q == OP_FILL) begin
            state_d     = ST_WR;
            ram_cs_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = dst_q;
            ram_wdata_d = data_q;
            dst_d       = dst_q + ADDR_W'(1);
          end else begin
            state_d    = ST_RD;
            ram_cs_d   = 1'b1;
            ram_addr_d = src_q;
            src_d      = src_q + ADDR_W'(1);
          end
        end
      end

      ST_FIN: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      dst_q       <= '0;
      src_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign cmd.done      = done_q;
  assign ram_cs        = ram_cs_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: a 32x8 synchronous RAM model on the ram_* port and an
// array-level reference of what each command should leave in memory.
module tb_ram_block_mover;
  import ram_block_mover_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  ram_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  ram_block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (bus),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model with a bench-side preload port; counts every chip-select edge.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  int                cs_count = 0;

  always @(posedge clk) begin
    if (pre_we) begin
      ram_mem[pre_addr] <= pre_data;
    end else if (ram_cs) begin
      cs_count <= cs_count + 1;
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] last_rsp = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk);
    pre_addr = ADDR_W'(a);
    pre_data = DATA_W'(d);
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
    ref_mem[a] = DATA_W'(d);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_mem%0d", tag, i), ram_mem[i], ref_mem[i]);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, bus.cmd_ready, 1);
  endtask

  task automatic drive(input op_e op, input int dst, input int src, input int len, input int data);
    bus.cmd_op    = op;
    bus.cmd_dst   = ADDR_W'(dst);
    bus.cmd_src   = ADDR_W'(src);
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = DATA_W'(data);
    bus.cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input op_e op, input int dst, input int src,
                         input int len, input int data, input bit hold);
    int exp_lat, exp_cs, k, done_k, done_cnt, stray_rsp, busy_rdy, cs0;
    logic [DATA_W-1:0] exp_rsp;
    logic rsp_at_done;
    logic [DATA_W-1:0] rsp_data_at_done;
    bit seen;

    exp_rsp = last_rsp;
    case (op)
      OP_READ: begin
        exp_rsp = ref_mem[dst % DEPTH];
        exp_lat = 3;
        exp_cs  = 1;
      end
      OP_WRITE: begin
        ref_mem[dst % DEPTH] = DATA_W'(data);
        exp_lat = 2;
        exp_cs  = 1;
      end
      OP_FILL: begin
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % DEPTH] = DATA_W'(data);
        exp_lat = len + 1;
        exp_cs  = len;
      end
      default: begin
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
        exp_lat = 3 * len + 1;
        exp_cs  = 2 * len;
      end
    endcase

    wait_ready(tag);
    cs0 = cs_count;
    drive(op, dst, src, len, data);
    @(posedge clk);
    #1;
    if (hold) begin
      bus.cmd_op   = 2'($urandom_range(0, 3));
      bus.cmd_dst  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.cmd_src  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.cmd_len  = LEN_W'($urandom_range(0, 3));
      bus.cmd_data = DATA_W'($urandom_range(0, 255));
    end else begin
      bus.cmd_valid = 1'b0;
    end

    k = 1; seen = 0; done_k = -1; done_cnt = 0; stray_rsp = 0; busy_rdy = 0;
    rsp_at_done = 1'b0; rsp_data_at_done = '0;
    while (!seen && k <= 200) begin
      if (bus.done === 1'b1) begin
        seen = 1;
        done_k = k;
        done_cnt++;
        rsp_at_done = bus.rsp_valid;
        rsp_data_at_done = bus.rsp_data;
        bus.cmd_valid = 1'b0;
      end else begin
        if (bus.rsp_valid !== 1'b0) stray_rsp++;
        @(posedge clk);
        #1;
        k++;
      end
      if (bus.cmd_ready !== 1'b0) busy_rdy++;
    end
    bus.cmd_valid = 1'b0;

    chk({tag, "_latency"}, done_k, exp_lat);
    chk({tag, "_rsp_valid_at_done"}, rsp_at_done, (op == OP_READ) ? 1 : 0);
    if (op == OP_READ) begin
      chk({tag, "_rsp_data"}, rsp_data_at_done, exp_rsp);
      last_rsp = exp_rsp;
    end
    chk({tag, "_stray_rsp"}, stray_rsp, 0);
    chk({tag, "_ready_while_busy"}, busy_rdy, 0);
    chk({tag, "_cs_edges"}, cs_count - cs0, exp_cs);

    @(posedge clk);
    #1;
    chk({tag, "_done_single_pulse"}, bus.done, 0);
    chk({tag, "_rsp_valid_single_pulse"}, bus.rsp_valid, 0);
    chk({tag, "_ready_after_done"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_data_held"}, bus.rsp_data, last_rsp);
    chk({tag, "_done_count"}, done_cnt, 1);
    @(posedge clk);
    #1;
    chk({tag, "_no_second_accept"}, bus.cmd_ready, 1);
    @(negedge clk);
    check_mem(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_ram_cs"}, ram_cs, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    op_e rop;
    int done_seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_dst   = '0;
    bus.cmd_src   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) poke(i, i);

    run_cmd("write5",  OP_WRITE, 5, 0, 0, 8'hA5, 1'b0);
    run_cmd("read5",   OP_READ,  5, 0, 0, 0,     1'b0);
    run_cmd("fill_wrap", OP_FILL, 30, 0, 4, 8'h3C, 1'b0);
    chk("fill_wrap_addr2_untouched", ram_mem[2], 8'd2);

    for (int i = 0; i < 16; i++) poke(i, i);
    run_cmd("copy16", OP_COPY, 16, 0, 16, 0, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("copy16_dst%0d", i), ram_mem[16 + i], i);

    poke(0, 11); poke(1, 22); poke(2, 33); poke(3, 44);
    run_cmd("copy_overlap", OP_COPY, 1, 0, 3, 0, 1'b0);
    chk("copy_overlap_m3", ram_mem[3], 11);

    run_cmd("fill_len0_hold", OP_FILL, 9, 0, 0, 8'hEE, 1'b1);
    run_cmd("copy_len0", OP_COPY, 4, 20, 0, 0, 1'b0);
    run_cmd("fill_full", OP_FILL, 7, 0, 32, 8'h5A, 1'b0);
    run_cmd("read_last", OP_READ, 31, 0, 0, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) poke(i, $urandom_range(0, 255));
    for (int t = 0; t < 25; t++) begin
      rop = op_e'($urandom_range(0, 3));
      run_cmd($sformatf("rnd%0d", t), rop, $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1),
              ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40),
              $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    // Abort a COPY part-way through with an asynchronous reset.
    wait_ready("abort");
    drive(OP_COPY, 16, 0, 16, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) done_seen++;
    end
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 if (bus.done !== 1'b0 || bus.rsp_valid !== 1'b0) done_seen++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 if (bus.done !== 1'b0) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_ready_after_release", bus.cmd_ready, 1);
    chk("abort_ram_cs_idle", ram_cs, 0);

    last_rsp = '0;
    for (int i = 0; i < DEPTH; i++) poke(i, i ^ 8'h5A);
    run_cmd("post_abort_write", OP_WRITE, 12, 0, 0, 8'hC3, 1'b0);
    run_cmd("post_abort_read",  OP_READ,  12, 0, 0, 0,     1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
